// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus levels, WM8731 address and the target receiver state encoding.
package i2c_pkg;

    localparam logic [6:0] WM8731_ADDR = 7'h1A;
    localparam logic       I2C_ACK     = 1'b0;
    localparam logic       I2C_NACK    = 1'b1;
    localparam logic       I2C_WRITE   = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ACK_A     = 3'd2,
        ST_DATA1     = 3'd3,
        ST_ACK_1     = 3'd4,
        ST_DATA2     = 3'd5,
        ST_ACK_2     = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_e;

    // Byte phase that follows a completed acknowledge slot.
    function automatic state_e after_ack(input state_e s);
        case (s)
            ST_ACK_A: return ST_DATA1;
            ST_ACK_1: return ST_DATA2;
            default:  return ST_WAIT_STOP;
        endcase
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the system clock domain and produces registered
// SCL edge and START/STOP pulses for any I2C receiver.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_s_o,
    output logic sda_s_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_rise_q;
    logic                   scl_fall_q;
    logic                   start_q;
    logic                   stop_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Flops reset to the idle-bus level (both lines high) so reset release
    // cannot fabricate a START.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a real shift chain.
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            scl_rise_q <= scl_s & ~scl_prev_q;
            scl_fall_q <= ~scl_s & scl_prev_q;
            start_q    <= scl_s & sda_prev_q & ~sda_s;
            stop_q     <= scl_s & ~sda_prev_q & sda_s;
        end
    end

    assign scl_s_o    = scl_s;
    assign sda_s_o    = sda_s;
    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target modelling the WM8731 control port: accepts
// address + two data bytes and presents the 16-bit word with a valid pulse.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = WM8731_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        frame_err
);

    logic unused_scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk_i     (clock),
        .rst_i     (reset),
        .scl_i     (i2c_sclk),
        .sda_i     (i2c_sdat),
        .scl_s_o   (unused_scl_s),
        .sda_s_o   (sda_s),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start),
        .stop_o    (stop)
    );

    state_e      state_q,     state_d;
    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  byte1_q,     byte1_d;
    logic [7:0]  byte2_q,     byte2_d;
    logic        ack_pend_q,  ack_pend_d;
    logic        ack_q,       ack_d;
    logic [1:0]  acked_cnt_q, acked_cnt_d;
    logic        overrun_q,   overrun_d;
    logic [15:0] rx_data_q,   rx_data_d;
    logic        rx_valid_q,  rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  byte_in;
    logic        frame_good;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte1_q     <= '0;
            byte2_q     <= '0;
            ack_pend_q  <= 1'b0;
            ack_q       <= 1'b0;
            acked_cnt_q <= '0;
            overrun_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte1_q     <= byte1_d;
            byte2_q     <= byte2_d;
            ack_pend_q  <= ack_pend_d;
            ack_q       <= ack_d;
            acked_cnt_q <= acked_cnt_d;
            overrun_q   <= overrun_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte1_d     = byte1_q;
        byte2_d     = byte2_q;
        ack_pend_d  = ack_pend_q;
        ack_d       = ack_q;
        acked_cnt_d = acked_cnt_q;
        overrun_d   = overrun_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        byte_in     = {shift_q[6:0], sda_s};
        frame_good  = (acked_cnt_q == 2'd3) && !overrun_q;

        if (start) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = '0;
            acked_cnt_d = '0;
            overrun_d   = 1'b0;
            ack_pend_d  = 1'b0;
            ack_d       = 1'b0;
            frame_err_d = (state_q != ST_IDLE) && !frame_good;
        end else if (stop) begin
            if (state_q != ST_IDLE) begin
                if (frame_good) begin
                    rx_data_d  = {byte1_q, byte2_q};
                    rx_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            state_d    = ST_IDLE;
            ack_pend_d = 1'b0;
            ack_d      = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_DATA1, ST_DATA2, ST_WAIT_STOP: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                ST_ADDR: begin
                                    if (byte_in[7:1] == SLAVE_ADDR && byte_in[0] == I2C_WRITE) begin
                                        ack_pend_d = 1'b1;
                                        state_d    = ST_ACK_A;
                                    end else begin
                                        state_d = ST_WAIT_STOP;
                                    end
                                end
                                ST_DATA1: begin
                                    byte1_d    = byte_in;
                                    ack_pend_d = 1'b1;
                                    state_d    = ST_ACK_1;
                                end
                                ST_DATA2: begin
                                    byte2_d    = byte_in;
                                    ack_pend_d = 1'b1;
                                    state_d    = ST_ACK_2;
                                end
                                default: overrun_d = 1'b1;
                            endcase
                        end
                    end
                end
                // First SCL fall drives the ACK low, the second releases it.
                ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
                    if (scl_fall) begin
                        if (ack_pend_q) begin
                            ack_d      = 1'b1;
                            ack_pend_d = 1'b0;
                        end else begin
                            ack_d       = 1'b0;
                            bit_cnt_d   = '0;
                            acked_cnt_d = acked_cnt_q + 2'd1;
                            state_d     = after_ack(state_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic sda_level;
    assign sda_level = ack_q ? I2C_ACK : I2C_NACK;
    // Open drain: a NACK/idle level is left to the bus pull-up.
    assign i2c_sdat  = (sda_level == I2C_NACK) ? 1'bz : 1'b0;

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
